fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Instruction fetch stage; producer of the 64-bit IF_ID pipeline register read by decoder.
//   Keeps the PC and fetches words over a req/ack instruction-memory port.
//   Packs IF_ID = {pc[31:0], instr[31:0]} and honours stall from decode and redirect from execute.
//   Holds one in-flight fetch in a skid register so no instruction is lost or repeated.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC of the first fetch after reset
//   PC_STEP     4              PC increment per fetched word
//   WAIT_LIMIT  15             consecutive un-acked request cycles before fetch_err sets
// PORTS
//   clock        in   1   sole clock, rising edge
//   reset_n      in   1   asynchronous, active-low reset
//   stall        in   1   decode cannot accept IF_ID this cycle
//   redirect     in   1   flush and restart fetch at redirect_pc
//   redirect_pc  in   32  new PC; bits [1:0] forced to 0 internally
//   imem_req     out  1   fetch request to instruction memory
//   imem_addr    out  32  fetch address; stable while imem_req=1 and imem_ack=0
//   imem_ack     in   1   memory returns imem_rdata this cycle
//   imem_rdata   in   32  instruction word, valid when imem_ack=1
//   IF_ID        out  64  {pc, instr} to decoder
//   if_id_valid  out  1   IF_ID holds a live instruction
//   fetch_err    out  1   sticky memory-timeout flag
// BEHAVIOUR
//   Reset (async, reset_n=0): pc=RESET_PC, state=REQ.
//     Outputs: imem_req=0, imem_addr=RESET_PC, IF_ID=0, if_id_valid=0, fetch_err=0; skid empty.
//   First rising edge after reset_n rises: imem_req=1, imem_addr=pc.
//   Handshake: once raised, imem_req and imem_addr stay fixed until imem_ack=1.
//     imem_ack counts only while imem_req=1.
//   Consumption: decode takes IF_ID on any edge where if_id_valid=1 and stall=0.
//   States:
//     REQ:
//       - imem_req=1.
//       - Ack with slot free (if_id_valid=0 or stall=0):
//         IF_ID<={imem_addr,imem_rdata}, if_id_valid<=1, pc<=pc+PC_STEP, stay REQ.
//         With zero-latency acks the result is back-to-back fetches, one per cycle.
//       - Ack with slot full and stall=1: word goes to the skid register, pc advances, go HOLD.
//       - No ack and the slot is consumed: if_id_valid<=0.
//     HOLD:
//       - imem_req=0.
//       - When stall=0: skid moves to IF_ID, valid stays 1, go REQ.
//     DRAIN:
//       - Entered on redirect while a request is outstanding (imem_req=1, no ack that cycle).
//       - imem_req stays high on the old address; the acked data is discarded.
//       - Then go REQ with the redirect PC.
//   Redirect (highest priority, any state):
//     - Clears if_id_valid and the skid; pc<=redirect_pc.
//     - Ack in the same cycle as redirect: that data is discarded; next REQ uses redirect_pc.
//     - A redirect during DRAIN replaces the pending PC.
//     - stall is ignored in the redirect cycle.
//   Stall with if_id_valid=0: no effect.
//   PC arithmetic: 32-bit modulo, so 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
//   Timeout counter:
//     - Counts consecutive cycles with imem_req=1 and imem_ack=0; clears on ack.
//     - Reaching WAIT_LIMIT sets fetch_err. The flag is sticky until reset; fetching keeps waiting.
//   Reset mid-transaction: everything clears immediately.
//     The memory must also drop any pending ack.
// CONFIGURATION
//   FETCH_PERF_EN defined: adds two outputs.
//     - fetch_count [31:0]: increments on every load of IF_ID from memory or from skid.
//     - stall_count [31:0]: increments on every cycle with if_id_valid=1 and stall=1.
//     - Both saturate at 32'hFFFF_FFFF and reset to 0.
//   FETCH_PERF_EN undefined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
//   1. Reset, ack every cycle, rdata=addr^32'hA5A5_0000.
//      -> IF_ID 64'h0000_0000_A5A5_0000, then 64'h0000_0004_A5A5_0004, one per cycle.
//   2. stall=1 for 3 cycles while acking.
//      -> IF_ID holds pc 0x4; pc 0x8 goes to skid; imem_req=0 in HOLD.
//      -> After release, IF_ID pc 0x8 then 0xC; no gap, no duplicate.
//   3. Ack latency 3; redirect_pc=32'h100 one cycle after req.
//      -> imem_req held on the old addr until ack; old data never valid.
//      -> Next valid IF_ID pc=0x100.
//   4. Redirect to 0x200 in the same cycle as an ack.
//      -> Acked word dropped; if_id_valid=0 next cycle; next request imem_addr=0x200.
//   5. Ack never returned.
//      -> fetch_err=1 after 15 request cycles; stays 1 after later acks; 0 only after reset_n=0.
//   6. FETCH_PERF_EN: scenario 2.
//      -> stall_count=3; fetch_count equals the number of valid IF_ID loads.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack instruction-memory port, IF_ID register and one-entry skid.
// Optional FETCH_PERF_EN adds saturating fetch_count / stall_count outputs.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] PC_STEP    = 32'd4,
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [63:0] IF_ID,
    output logic        if_id_valid,
`ifdef FETCH_PERF_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    output logic        fetch_err
);

    localparam int unsigned CW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {
        S_REQ,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t      r_state, w_state_n;
    logic        r_req, w_req_n;
    logic [31:0] r_addr, w_addr_n;
    logic [31:0] r_pend, w_pend_n;
    logic [63:0] r_ifid, w_ifid_n;
    logic        r_valid, w_valid_n;
    logic [63:0] r_skid, w_skid_n;
    logic        w_load;
    logic        w_ack;
    logic        w_wait;
    logic [31:0] w_redir_pc;
    logic [CW-1:0] r_wait_cnt;
    logic        r_err;

    assign w_ack      = imem_ack & r_req;
    assign w_wait     = r_req & ~imem_ack;
    assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_REQ;
            r_req   <= 1'b0;
            r_addr  <= RESET_PC;
            r_pend  <= RESET_PC;
            r_ifid  <= '0;
            r_valid <= 1'b0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_n;
            r_req   <= w_req_n;
            r_addr  <= w_addr_n;
            r_pend  <= w_pend_n;
            r_ifid  <= w_ifid_n;
            r_valid <= w_valid_n;
            r_skid  <= w_skid_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_req_n   = r_req;
        w_addr_n  = r_addr;
        w_pend_n  = r_pend;
        w_ifid_n  = r_ifid;
        w_valid_n = r_valid;
        w_skid_n  = r_skid;
        w_load    = 1'b0;
        case (r_state)
            S_REQ: begin
                w_req_n = 1'b1;
                if (redirect) begin
                    w_valid_n = 1'b0;
                    // An outstanding request must complete on its old address before restarting
                    if (w_wait) begin
                        w_state_n = S_DRAIN;
                        w_pend_n  = w_redir_pc;
                    end else begin
                        w_addr_n = w_redir_pc;
                    end
                end else if (w_ack) begin
                    w_addr_n = r_addr + PC_STEP;
                    if (!r_valid || !stall) begin
                        w_ifid_n  = {r_addr, imem_rdata};
                        w_valid_n = 1'b1;
                        w_load    = 1'b1;
                    end else begin
                        w_skid_n  = {r_addr, imem_rdata};
                        w_state_n = S_HOLD;
                        w_req_n   = 1'b0;
                    end
                end else if (r_valid && !stall) begin
                    w_valid_n = 1'b0;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_valid_n = 1'b0;
                    w_addr_n  = w_redir_pc;
                    w_state_n = S_REQ;
                    w_req_n   = 1'b1;
                end else if (!stall) begin
                    w_ifid_n  = r_skid;
                    w_load    = 1'b1;
                    w_state_n = S_REQ;
                    w_req_n   = 1'b1;
                end
            end
            S_DRAIN: begin
                w_valid_n = 1'b0;
                if (w_ack) begin
                    w_addr_n  = redirect ? w_redir_pc : r_pend;
                    w_state_n = S_REQ;
                end else if (redirect) begin
                    w_pend_n = w_redir_pc;
                end
            end
            default: begin
                w_state_n = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else if (w_wait) begin
            if (r_wait_cnt != CW'(WAIT_LIMIT))
                r_wait_cnt <= r_wait_cnt + CW'(1);
            if (r_wait_cnt == CW'(WAIT_LIMIT - 1))
                r_err <= 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_load && (r_fetch_cnt != '1))
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (r_valid && stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign fetch_count = r_fetch_cnt;
    assign stall_count = r_stall_cnt;
`endif

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign IF_ID       = r_ifid;
    assign if_id_valid = r_valid;
    assign fetch_err   = r_err;

endmodule
